// File: rtl/sorted_pkg.sv
// rtl/sorted_pkg.sv - shared state encodings and defaults for the sorted-output collector
package sorted_pkg;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DONE    = 2'd1,
    S_READ    = 2'd2
  } state_t;

  localparam int DEF_W = 32;
  localparam int DEF_N = 256;

endpackage

// File: rtl/word_buf.sv
// rtl/word_buf.sv - n x W single-port synchronous RAM with registered read data
module word_buf #(
  parameter int N = 256,
  parameter int W = 32,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [N];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Only the read register is reset so the readout port comes up at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sorted_collector.sv
// rtl/sorted_collector.sv - captures a sorted array, checks ordering, tracks stats, replays on request
module sorted_collector
  import sorted_pkg::*;
#(
  parameter int n  = DEF_N,
  parameter int W  = DEF_W,
  localparam int CW = $clog2(n + 1),
  localparam int AW = $clog2(n)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  dataIn,
  input  logic          R_I,
  input  logic          clear,
  input  logic          rd_req,
  output logic [W-1:0]  dataOut,
  output logic          R_O,
  output logic          done,
  output logic          sorted_ok,
  output logic [CW-1:0] viol_cnt,
  output logic [W-1:0]  min_val,
  output logic [W-1:0]  max_val,
  output logic          overrun
);

  localparam logic [AW-1:0] LAST_IDX = AW'(n - 1);

  state_t        r_state, w_next;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_rd_fin;
  logic [CW-1:0] r_viol;
  logic [W-1:0]  r_min, r_max, r_last;
  logic          r_ro, r_overrun;
  logic          w_cap, w_rd;
  logic [AW-1:0] w_addr;

  assign w_cap  = (r_state == S_COLLECT) && R_I && !clear;
  assign w_rd   = (r_state == S_READ) && !r_rd_fin && !clear;
  assign w_addr = w_cap ? r_wr_ptr : r_rd_ptr;

  word_buf #(.N(n), .W(W)) u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_cap),
    .i_re    (w_rd),
    .i_addr  (w_addr),
    .i_wdata (dataIn),
    .o_rdata (dataOut)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_COLLECT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_COLLECT;
    end else begin
      unique case (r_state)
        S_COLLECT: if (w_cap && r_wr_ptr == LAST_IDX) w_next = S_DONE;
        S_DONE:    if (rd_req) w_next = S_READ;
        S_READ:    if (r_rd_fin) w_next = S_COLLECT;
        default:   w_next = S_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_fin  <= 1'b0;
      r_viol    <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_last    <= '0;
      r_ro      <= 1'b0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_fin  <= 1'b0;
      r_viol    <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_last    <= '0;
      r_ro      <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (R_I && r_state != S_COLLECT) r_overrun <= 1'b1;
      unique case (r_state)
        S_COLLECT: begin
          if (R_I) begin
            // Pointer parks at the last index; the state change ends capture instead of a wrap.
            if (r_wr_ptr != LAST_IDX) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_last <= dataIn;
            if (r_wr_ptr == '0) begin
              r_min <= dataIn;
              r_max <= dataIn;
            end else begin
              if (r_last > dataIn) r_viol <= r_viol + CW'(1);
              if (dataIn < r_min)  r_min  <= dataIn;
              if (dataIn > r_max)  r_max  <= dataIn;
            end
          end
        end
        S_DONE: begin
          if (rd_req) begin
            r_rd_ptr <= '0;
            r_rd_fin <= 1'b0;
          end
        end
        S_READ: begin
          if (!r_rd_fin) begin
            r_ro <= 1'b1;
            if (r_rd_ptr == LAST_IDX) r_rd_fin <= 1'b1;
            else                      r_rd_ptr <= r_rd_ptr + AW'(1);
          end else begin
            r_ro     <= 1'b0;
            r_rd_fin <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_viol   <= '0;
            r_min    <= '0;
            r_max    <= '0;
            r_last   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign R_O       = r_ro;
  assign done      = (r_state != S_COLLECT);
  assign sorted_ok = done && (r_viol == '0);
  assign viol_cnt  = r_viol;
  assign min_val   = r_min;
  assign max_val   = r_max;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sorted_collector.sv
// tb/tb_sorted_collector.sv - table-driven and scoreboard bench for sorted_collector (n=4, W=32)
module tb_sorted_collector;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  dataIn;
  logic          R_I, clear, rd_req;
  logic [W-1:0]  dataOut;
  logic          R_O, done, sorted_ok, overrun;
  logic [CW-1:0] viol_cnt;
  logic [W-1:0]  min_val, max_val;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];

  typedef struct {
    logic          ri;
    logic [W-1:0]  d;
    logic          clr;
    logic          rq;
    logic          cap;
    logic          e_done;
    logic [CW-1:0] e_viol;
    logic [W-1:0]  e_min;
    logic [W-1:0]  e_max;
    logic          e_ovr;
    logic          ovr_chk;
    logic          e_ro;
  } vec_t;

  vec_t tv[$];

  sorted_collector #(.n(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .dataIn    (dataIn),
    .R_I       (R_I),
    .clear     (clear),
    .rd_req    (rd_req),
    .dataOut   (dataOut),
    .R_O       (R_O),
    .done      (done),
    .sorted_ok (sorted_ok),
    .viol_cnt  (viol_cnt),
    .min_val   (min_val),
    .max_val   (max_val),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic ri, input logic [W-1:0] d, input logic clr,
                              input logic rq, input logic cap, input logic e_done,
                              input logic [CW-1:0] e_viol, input logic [W-1:0] e_min,
                              input logic [W-1:0] e_max, input logic e_ovr,
                              input logic ovr_chk, input logic e_ro);
    vec_t v;
    v.ri = ri; v.d = d; v.clr = clr; v.rq = rq; v.cap = cap;
    v.e_done = e_done; v.e_viol = e_viol; v.e_min = e_min; v.e_max = e_max;
    v.e_ovr = e_ovr; v.ovr_chk = ovr_chk; v.e_ro = e_ro;
    tv.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string name, input logic e_done, input logic [CW-1:0] e_viol,
                            input logic [W-1:0] e_min, input logic [W-1:0] e_max,
                            input logic e_ovr, input logic ovr_chk, input logic e_ro);
    logic [CW+68:0] act, exp;
    logic a_ovr;
    a_ovr = ovr_chk ? overrun : e_ovr;
    exp = {e_done, e_done && (e_viol == '0), e_viol, e_ovr, e_ro, e_min, e_max};
    act = {done, sorted_ok, viol_cnt, a_ovr, R_O, min_val, max_val};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s {done,ok,viol,ovr,ro,min,max} act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name);
    logic [W-1:0] e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s dataOut act=%0d exp=<none queued>", name, dataOut);
    end else begin
      e = q.pop_front();
      if (dataOut !== e) begin
        errors++;
        $display("FAIL %s dataOut act=%0d exp=%0d", name, dataOut, e);
      end
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  initial begin
    int got;
    reset = 1'b0; dataIn = '0; R_I = 1'b0; clear = 1'b0; rd_req = 1'b0;

    //   ri d   clr rq cap | done viol min max ovr chk ro
    add(1, 3,  0, 0, 1,   0, 0, 3,  3,  0, 1, 0);  // 0  sorted 3,7,7,20
    add(1, 7,  0, 0, 1,   0, 0, 3,  7,  0, 1, 0);
    add(1, 7,  0, 0, 1,   0, 0, 3,  7,  0, 1, 0);
    add(1, 20, 0, 0, 1,   1, 0, 3,  20, 0, 1, 0);
    add(0, 0,  0, 1, 0,   1, 0, 3,  20, 0, 1, 0);  // 4  readout request
    add(0, 0,  0, 0, 0,   1, 0, 3,  20, 0, 1, 1);
    add(0, 0,  0, 1, 0,   1, 0, 3,  20, 0, 1, 1);  // rd_req ignored mid-burst
    add(0, 0,  0, 0, 0,   1, 0, 3,  20, 0, 1, 1);
    add(0, 0,  0, 0, 0,   1, 0, 3,  20, 0, 1, 1);
    add(0, 0,  0, 0, 0,   0, 0, 0,  0,  0, 1, 0);  // 9  burst over
    add(1, 9,  0, 0, 1,   0, 0, 9,  9,  0, 1, 0);  // 10 gapped 9,2,5,1
    add(0, 0,  0, 0, 0,   0, 0, 9,  9,  0, 1, 0);
    add(1, 2,  0, 0, 1,   0, 1, 2,  9,  0, 1, 0);
    add(0, 0,  0, 0, 0,   0, 1, 2,  9,  0, 1, 0);
    add(1, 5,  0, 0, 1,   0, 1, 2,  9,  0, 1, 0);
    add(0, 0,  0, 0, 0,   0, 1, 2,  9,  0, 1, 0);
    add(1, 1,  0, 0, 1,   1, 2, 1,  9,  0, 1, 0);
    add(0, 0,  1, 0, 0,   0, 0, 0,  0,  0, 1, 0);  // 17 clear from done
    add(1, 1,  0, 0, 1,   0, 0, 1,  1,  0, 1, 0);  // 18 R_I held 6 cycles
    add(1, 2,  0, 0, 1,   0, 0, 1,  2,  0, 1, 0);
    add(1, 3,  0, 0, 1,   0, 0, 1,  3,  0, 1, 0);
    add(1, 4,  0, 0, 1,   1, 0, 1,  4,  0, 1, 0);
    add(1, 5,  0, 0, 0,   1, 0, 1,  4,  1, 1, 0);
    add(1, 6,  0, 0, 0,   1, 0, 1,  4,  1, 1, 0);
    add(0, 0,  0, 1, 0,   1, 0, 1,  4,  1, 1, 0);  // 24 read back 1..4
    add(0, 0,  0, 0, 0,   1, 0, 1,  4,  1, 1, 1);
    add(0, 0,  0, 0, 0,   1, 0, 1,  4,  1, 1, 1);
    add(0, 0,  0, 0, 0,   1, 0, 1,  4,  1, 1, 1);
    add(0, 0,  0, 0, 0,   1, 0, 1,  4,  1, 1, 1);
    add(0, 0,  0, 0, 0,   0, 0, 0,  0,  0, 0, 0);  // 29
    add(1, 10, 0, 0, 1,   0, 0, 10, 10, 0, 0, 0);  // 30 clear mid-burst
    add(1, 11, 0, 0, 1,   0, 0, 10, 11, 0, 0, 0);
    add(1, 12, 0, 0, 1,   0, 0, 10, 12, 0, 0, 0);
    add(1, 13, 0, 0, 1,   1, 0, 10, 13, 0, 0, 0);
    add(0, 0,  0, 1, 0,   1, 0, 10, 13, 0, 0, 0);
    add(0, 0,  0, 0, 0,   1, 0, 10, 13, 0, 0, 1);
    add(0, 0,  0, 0, 0,   1, 0, 10, 13, 0, 0, 1);
    add(0, 0,  1, 0, 0,   0, 0, 0,  0,  0, 1, 0);  // 37 clear on 2nd word
    add(1, 99, 1, 0, 0,   0, 0, 0,  0,  0, 1, 0);  // 38 clear beats R_I
    add(1, 50, 0, 0, 1,   0, 0, 50, 50, 0, 1, 0);  // 39 capture restarts at slot 0
    add(1, 40, 0, 0, 1,   0, 1, 40, 50, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 0, 0, 0, 0, 0, 1, 0);
    chk_int("reset_dataOut", int'(dataOut), 0);
    reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      R_I = tv[i].ri; dataIn = tv[i].d; clear = tv[i].clr; rd_req = tv[i].rq;
      if (tv[i].cap) q.push_back(tv[i].d);
      step();
      if (tv[i].clr) q.delete();
      chk_status($sformatf("row%0d", i), tv[i].e_done, tv[i].e_viol, tv[i].e_min,
                 tv[i].e_max, tv[i].e_ovr, tv[i].ovr_chk, tv[i].e_ro);
      if (R_O) chk_word($sformatf("row%0d_word", i));
      if (i == 9 || i == 29) chk_int($sformatf("row%0d_drained", i), q.size(), 0);
    end
    R_I = 1'b0; clear = 1'b0; rd_req = 1'b0; dataIn = '0;

    // Asynchronous reset between edges, mid-collect.
    #2;
    reset = 1'b0;
    #1;
    chk_status("async_rst", 0, 0, 0, 0, 0, 1, 0);
    chk_int("async_rst_dataOut", int'(dataOut), 0);
    q.delete();
    #1;
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      R_I = 1'b1; dataIn = W'(5 + k);
      q.push_back(W'(5 + k));
      step();
    end
    R_I = 1'b0;
    chk_status("rst_cap", 1, 0, 5, 8, 0, 1, 0);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (R_O) begin
        chk_word($sformatf("rst_word%0d", got));
        got++;
      end
    end
    chk_int("rst_burst_len", got, N);
    chk_int("rst_drained", q.size(), 0);
    chk_status("rst_end", 0, 0, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
